// File: rtl/fft_pkg.sv
// Shared FFT package: default sample width, log2 for sizing and bit reversal of bin indices.
package fft_pkg;

  localparam int unsigned FftWidth = 16;
  // Widest bin index supported (N up to 4096)
  localparam int unsigned MaxLog2  = 12;

  typedef logic [MaxLog2-1:0] fft_idx_t;

  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Reverses the low w bits of x; bits at and above w come back as zero.
  function automatic fft_idx_t bitrev(input fft_idx_t x, input int unsigned w);
    fft_idx_t r;
    r = {<<{x}};
    return r >> (MaxLog2 - w);
  endfunction

endpackage

// File: rtl/fft_reorder_buffer_if.sv
// Streaming sample bus into and out of the reorder buffer.
// odata_idx exists only when REORDER_INDEX_EN is defined.
interface fft_reorder_buffer_if
  import fft_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = FftWidth
);
  localparam int unsigned IdxW = log2(N);

  logic             idata_en;
  logic [WIDTH-1:0] idata_r;
  logic [WIDTH-1:0] idata_i;
  logic             odata_en;
  logic [WIDTH-1:0] odata_r;
  logic [WIDTH-1:0] odata_i;

`ifdef REORDER_INDEX_EN
  logic [IdxW-1:0]  odata_idx;

  modport master (
    output idata_en, idata_r, idata_i,
    input  odata_en, odata_r, odata_i, odata_idx
  );

  modport slave (
    input  idata_en, idata_r, idata_i,
    output odata_en, odata_r, odata_i, odata_idx
  );
`else
  modport master (
    output idata_en, idata_r, idata_i,
    input  odata_en, odata_r, odata_i
  );

  modport slave (
    input  idata_en, idata_r, idata_i,
    output odata_en, odata_r, odata_i
  );
`endif

endinterface

// File: rtl/reorder_ram.sv
// Simple dual-port memory with one write port and a registered read port.
// Deliberately unreset so it maps onto block RAM.
module reorder_ram #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder stage: bit-reversed frames in, natural-order frames out, no gaps.
// Define REORDER_INDEX_EN to add the odata_idx output and its alignment pipeline.
module fft_reorder_buffer
  import fft_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = FftWidth
) (
  input logic                 clock,
  input logic                 reset,
  fft_reorder_buffer_if.slave bus
);

  localparam int unsigned AW = log2(N);
  localparam logic [AW-1:0] LastIdx = AW'(N - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  logic [AW-1:0]      wr_count_q, wr_count_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_start_q, rd_start_d;
  logic [AW-1:0]      wr_idx;
  logic [0:0]         state_q, state_d;
  logic [AW-1:0]      rd_count_q, rd_count_d;
  logic               rd_bank_q, rd_bank_d;
  logic               rd_valid_q;
  logic [2*WIDTH-1:0] rd_data;
  logic               odata_en_q;
  logic [WIDTH-1:0]   odata_r_q, odata_i_q;

  // Write side: a drop of idata_en abandons the partial frame in place.
  always_comb begin
    wr_count_d = '0;
    wr_bank_d  = wr_bank_q;
    rd_start_d = 1'b0;
    if (bus.idata_en) begin
      wr_count_d = wr_count_q + AW'(1);
      if (wr_count_q == LastIdx) begin
        wr_bank_d  = ~wr_bank_q;
        rd_start_d = 1'b1;
      end
    end
  end

  assign wr_idx = AW'(bitrev(fft_idx_t'(wr_count_q), AW));

  always_comb begin
    state_d    = state_q;
    rd_count_d = rd_count_q;
    rd_bank_d  = rd_bank_q;
    case (state_q)
      StIdle: begin
        rd_count_d = '0;
        if (rd_start_q) begin
          state_d   = StRead;
          rd_bank_d = ~wr_bank_q;
        end
      end
      StRead: begin
        if (rd_count_q == LastIdx) begin
          rd_count_d = '0;
          // A frame finishing exactly now chains straight into the next read
          if (rd_start_q) begin
            rd_bank_d = ~wr_bank_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          rd_count_d = rd_count_q + AW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_count_q <= '0;
      wr_bank_q  <= 1'b0;
      rd_start_q <= 1'b0;
      state_q    <= StIdle;
      rd_count_q <= '0;
      rd_bank_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      odata_en_q <= 1'b0;
      odata_r_q  <= '0;
      odata_i_q  <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      wr_bank_q  <= wr_bank_d;
      rd_start_q <= rd_start_d;
      state_q    <= state_d;
      rd_count_q <= rd_count_d;
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= (state_q == StRead);
      odata_en_q <= rd_valid_q;
      odata_r_q  <= rd_valid_q ? rd_data[2*WIDTH-1:WIDTH] : '0;
      odata_i_q  <= rd_valid_q ? rd_data[WIDTH-1:0] : '0;
    end
  end

  reorder_ram #(
    .AW (AW + 1),
    .DW (2 * WIDTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (bus.idata_en),
    .waddr_i ({wr_bank_q, wr_idx}),
    .wdata_i ({bus.idata_r, bus.idata_i}),
    .raddr_i ({rd_bank_q, rd_count_q}),
    .rdata_o (rd_data)
  );

  assign bus.odata_en = odata_en_q;
  assign bus.odata_r  = odata_r_q;
  assign bus.odata_i  = odata_i_q;

`ifdef REORDER_INDEX_EN
  logic [AW-1:0] rd_idx_q, odata_idx_q;

  // Index rides alongside the RAM read latency so it lines up with odata_r
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_idx_q    <= '0;
      odata_idx_q <= '0;
    end else begin
      rd_idx_q    <= rd_count_q;
      odata_idx_q <= rd_valid_q ? rd_idx_q : '0;
    end
  end

  assign bus.odata_idx = odata_idx_q;
`endif

endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed bench for fft_reorder_buffer at N=16: table of frame patterns plus abort/reset sequences.
module tb_fft_reorder_buffer;

  localparam int unsigned N = 16;
  localparam int unsigned W = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fft_reorder_buffer_if #(.N(N), .WIDTH(W)) bus ();

  fft_reorder_buffer #(
    .N     (N),
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int idle_bad = 0;

  logic [15:0] q_r[$];
  logic [15:0] q_i[$];
  int          q_idx[$];
  int          q_cyc[$];

  typedef struct {
    logic [15:0] rb;
    logic [15:0] ib;
    int          nf;
    int          gap;
    int          exp_count;
    int          exp_lat;
    int          exp_span;
    int          exp_breaks;
    string       tag;
  } vec_t;

  vec_t tbl[5];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      if (bus.odata_en) begin
        q_r.push_back(bus.odata_r);
        q_i.push_back(bus.odata_i);
        q_cyc.push_back(cyc);
`ifdef REORDER_INDEX_EN
        q_idx.push_back(int'(bus.odata_idx));
`endif
      end else begin
        if (bus.odata_r != '0 || bus.odata_i != '0) idle_bad++;
`ifdef REORDER_INDEX_EN
        if (bus.odata_idx != '0) idle_bad++;
`endif
      end
    end
  end

  function automatic logic [3:0] br4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic en, input logic [15:0] r, input logic [15:0] i);
    @(posedge clock);
    #1;
    bus.idata_en = en;
    bus.idata_r  = r;
    bus.idata_i  = i;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 16'h0);
  endtask

  task automatic clear_q();
    q_r.delete();
    q_i.delete();
    q_idx.delete();
    q_cyc.delete();
  endtask

  // Frame f, input k carries offset 16f + bitrev(k); natural output j should carry offset j.
  task automatic send(input logic [15:0] rb, input logic [15:0] ib, input int nf, input int gap,
                      output int first_in);
    first_in = 0;
    for (int f = 0; f < nf; f++) begin
      for (int k = 0; k < int'(N); k++) begin
        logic [15:0] off;
        off = 16'(16 * f + int'(br4(4'(k))));
        drive(1'b1, rb + off, ib - off);
        if (f == 0 && k == 0) first_in = cyc + 1;
      end
      if (f < nf - 1) idle(gap);
    end
  endtask

  task automatic run_check(input string tag, input logic [15:0] rb, input logic [15:0] ib,
                           input int first_in, input int exp_count, input int exp_lat,
                           input int exp_span, input int exp_breaks);
    int n;
    int breaks;
    n = q_r.size();
    check({tag, ".count"}, n, exp_count);
    if (n > 0) begin
      check({tag, ".latency"}, q_cyc[0] - first_in, exp_lat);
      check({tag, ".span"}, q_cyc[n-1] - q_cyc[0], exp_span);
      breaks = 0;
      for (int j = 1; j < n; j++) if (q_cyc[j] - q_cyc[j-1] != 1) breaks++;
      check({tag, ".gaps"}, breaks, exp_breaks);
    end
    for (int j = 0; j < n && j < exp_count; j++) begin
      logic [15:0] er, ei;
      er = rb + 16'(j);
      ei = ib - 16'(j);
      check($sformatf("%s.r[%0d]", tag, j), int'(q_r[j]), int'(er));
      check($sformatf("%s.i[%0d]", tag, j), int'(q_i[j]), int'(ei));
`ifdef REORDER_INDEX_EN
      check($sformatf("%s.idx[%0d]", tag, j), q_idx[j], j % int'(N));
`endif
    end
  endtask

  initial begin
    int fi;

    tbl[0] = '{16'h0000, 16'h0000, 1, 0, 16, 18, 15, 0, "single"};
    tbl[1] = '{16'h8000, 16'h7FFF, 1, 0, 16, 18, 15, 0, "single_hi"};
    tbl[2] = '{16'h0000, 16'h1000, 3, 0, 48, 18, 47, 0, "b2b3"};
    tbl[3] = '{16'h0A00, 16'h0B00, 2, 5, 32, 18, 36, 1, "gap5"};
    tbl[4] = '{16'hFFF0, 16'h0005, 3, 1, 48, 18, 49, 2, "gap1_wrap"};

    bus.idata_en = 1'b0;
    bus.idata_r  = '0;
    bus.idata_i  = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset.odata_en", int'(bus.odata_en), 0);
    check("reset.odata_r", int'(bus.odata_r), 0);
    check("reset.odata_i", int'(bus.odata_i), 0);
    reset = 1'b1;
    idle(2);

    for (int t = 0; t < 5; t++) begin
      clear_q();
      send(tbl[t].rb, tbl[t].ib, tbl[t].nf, tbl[t].gap, fi);
      idle(int'(N) + 8);
      run_check(tbl[t].tag, tbl[t].rb, tbl[t].ib, fi, tbl[t].exp_count, tbl[t].exp_lat,
                tbl[t].exp_span, tbl[t].exp_breaks);
    end

    // Partial frame of 10 samples must vanish; the following full frame reuses the bank.
    clear_q();
    for (int k = 0; k < 10; k++) drive(1'b1, 16'hBEEF, 16'hDEAD);
    idle(1);
    send(16'h0100, 16'h0200, 1, 0, fi);
    idle(int'(N) + 8);
    run_check("abort", 16'h0100, 16'h0200, fi, 16, 18, 15, 0);

    // Reset in the middle of a read clears outputs at once and suppresses the rest.
    clear_q();
    send(16'h0300, 16'h0400, 1, 0, fi);
    idle(5);
    check("rst.busy", int'(bus.odata_en), 1);
    #3;
    reset = 1'b0;
    #1;
    check("rst.odata_en", int'(bus.odata_en), 0);
    check("rst.odata_r", int'(bus.odata_r), 0);
    check("rst.odata_i", int'(bus.odata_i), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    clear_q();
    idle(int'(N) + 8);
    check("rst.quiet", q_r.size(), 0);
    clear_q();
    send(16'h0500, 16'h0600, 1, 0, fi);
    idle(int'(N) + 8);
    run_check("rst.after", 16'h0500, 16'h0600, fi, 16, 18, 15, 0);

    check("idle_outputs_zero", idle_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
